// File: rtl/segscan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner:
// glyph table, special segment patterns, load modes, BCD sizing.
package segscan_pkg;

   // Active-high glyphs, {a,b,c,d,e,f,g} with bit6 = a
   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   localparam logic [6:0] SEG_DASH = 7'b0000001;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

   localparam logic MODE_HEX = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // Decimal digits needed to hold any w-bit unsigned value
   function automatic int bcd_digits(input int w);
      return (w * 3) / 10 + 1;
   endfunction

endpackage

// File: rtl/m_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit
// per cycle MSB first; done/bcd present the final step.
module m_bin2bcd
   import segscan_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int BCD_D  = 10
) (
   input  logic                 w_clk,
   input  logic                 w_rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    din,
   output logic                 busy,
   output logic                 done,
   output logic [4*BCD_D-1:0]   bcd
);

   localparam int CW = $clog2(DATA_W + 1);

   logic [DATA_W-1:0]  shreg;
   logic [4*BCD_D-1:0] acc;
   logic [4*BCD_D-1:0] adj;
   logic [4*BCD_D-1:0] step;
   logic [CW-1:0]      left;

   // Add 3 to every digit >= 5, then shift in the next binary bit
   always_comb begin
      adj = acc;
      for (int d = 0; d < BCD_D; d++) begin
         if (acc[4*d +: 4] >= 4'd5)
            adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      step = {adj[4*BCD_D-2:0], shreg[DATA_W-1]};
   end

   // The last step's result is handed out on the edge busy falls
   assign done = busy && (left == CW'(1));
   assign bcd  = step;

   // Conversion state: capture on start, step while busy
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         busy  <= 1'b0;
         left  <= '0;
         shreg <= '0;
         acc   <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         left  <= CW'(DATA_W);
         shreg <= din;
         acc   <= '0;
      end else if (busy) begin
         acc   <= step;
         shreg <= shreg << 1;
         left  <= left - 1'b1;
         if (left == CW'(1))
            busy <= 1'b0;
      end
   end

endmodule

// File: rtl/m_7segscan.sv
// Time-multiplexed NDIG-digit 7-segment driver with hex or
// decimal load, leading-zero blanking and overflow dash.
module m_7segscan
   import segscan_pkg::*;
#(
   parameter int NDIG       = 8,
   parameter int DATA_W     = 32,
   parameter int DIV        = 100000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic [DATA_W-1:0] w_din,
   input  logic              w_load,
   input  logic              w_mode_dec,
   input  logic              w_blank_lz,
   output logic [6:0]        r_sg,
   output logic [NDIG-1:0]   r_an,
   output logic              r_busy,
   output logic              r_ovf
);

   localparam int BCD_D = bcd_digits(DATA_W);
   localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DW    = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int HW    = DATA_W + 4 * NDIG;
   localparam int BW    = 4 * BCD_D + 4 * NDIG;
   localparam bit AL    = (ACTIVE_LOW != 0);

   logic [CW-1:0]      r_cnt;
   logic [DW-1:0]      r_digit;
   logic [3:0]         nib [NDIG];
   logic               mode;
   logic               tick;
   logic               accept;
   logic               start;
   logic               done;
   logic               busy;
   logic [4*BCD_D-1:0] bcd;
   logic [HW-1:0]      hex_pad;
   logic [BW-1:0]      bcd_pad;
   logic               ovf_next;
   logic               nz;
   logic [3:0]         cur;
   logic [6:0]         seg;
   logic [NDIG-1:0]    an_hot;
   logic [DW-1:0]      digit_next;

   assign accept  = w_load && !busy;
   assign start   = accept && (w_mode_dec == MODE_DEC);
   assign hex_pad = HW'(w_din);
   assign bcd_pad = BW'(bcd);
   assign r_busy  = busy;

   m_bin2bcd #(
      .DATA_W (DATA_W),
      .BCD_D  (BCD_D)
   ) u_conv (
      .w_clk  (w_clk),
      .w_rst  (w_rst),
      .start  (start),
      .din    (w_din),
      .busy   (busy),
      .done   (done),
      .bcd    (bcd)
   );

   // Any non-zero decimal digit beyond the display means overflow
   always_comb begin
      ovf_next = 1'b0;
      for (int i = 0; i < BCD_D; i++) begin
         if (i >= NDIG && bcd[4*i +: 4] != 4'd0)
            ovf_next = 1'b1;
      end
   end

   // Remember the mode of the last accepted load
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst)
         mode <= MODE_HEX;
      else if (accept)
         mode <= w_mode_dec;
   end

   // Digit nibbles: hex loads directly, decimal on conversion end
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         for (int i = 0; i < NDIG; i++)
            nib[i] <= 4'd0;
         r_ovf <= 1'b0;
      end else if (accept && w_mode_dec == MODE_HEX) begin
         for (int i = 0; i < NDIG; i++)
            nib[i] <= hex_pad[4*i +: 4];
         r_ovf <= 1'b0;
      end else if (done && mode == MODE_DEC) begin
         for (int i = 0; i < NDIG; i++)
            nib[i] <= bcd_pad[4*i +: 4];
         r_ovf <= ovf_next;
      end
   end

   assign tick = (r_cnt == CW'(DIV - 1));

   // Per-digit dwell counter
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst)
         r_cnt <= '0;
      else if (tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   // Segment pattern for the digit about to be shown
   always_comb begin
      nz  = 1'b0;
      cur = 4'd0;
      for (int i = 0; i < NDIG; i++) begin
         if (DW'(i) == r_digit)
            cur = nib[i];
         if (i >= int'(r_digit) && nib[i] != 4'd0)
            nz = 1'b1;
      end
      if (r_ovf)
         seg = SEG_DASH;
      else if (w_blank_lz && r_digit != '0 && !nz)
         seg = SEG_OFF;
      else
         seg = GLYPH[cur];
   end

   assign an_hot     = NDIG'(1) << r_digit;
   assign digit_next = (r_digit == DW'(NDIG - 1)) ?
                       '0 : r_digit + 1'b1;

   // r_digit points at the next digit; anode and segments move together
   always_ff @(posedge w_clk or posedge w_rst) begin
      if (w_rst) begin
         r_digit <= '0;
         r_an    <= AL ? '1 : '0;
         r_sg    <= AL ? ~SEG_OFF : SEG_OFF;
      end else if (tick) begin
         r_digit <= digit_next;
         r_an    <= AL ? ~an_hot : an_hot;
         r_sg    <= AL ? ~seg : seg;
      end
   end

endmodule
